// File: rtl/loader_pkg.sv
// Shared types and helpers for the boot-time program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;

  // Header and data words arrive most-significant byte first.
  localparam bit HDR_MSB_FIRST = 1'b1;

  function automatic logic [WORD_W-1:0] join_bytes(input logic [BYTE_W-1:0] first,
                                                   input logic [BYTE_W-1:0] second);
    return HDR_MSB_FIRST ? {first, second} : {second, first};
  endfunction

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/idle_timer.sv
// Idle-cycle counter; tc_c fires in the cycle the count is about to reach TIMEOUT_CYCLES.
module idle_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc_c
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != CW'(TIMEOUT_CYCLES))) begin
      count_q <= count_q + CW'(1);
    end
  end

  // A clear in the same cycle (accepted byte) always beats expiry.
  assign tc_c = enable && !clear && (count_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/program_loader.sv
// Assembles a length-prefixed big-endian byte stream into instruction-memory writes
// and holds the CPU in reset until a complete program has been loaded.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned DEPTH          = 2048,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_data,
  output logic                          mem_we,
  output logic [addr_width(DEPTH)-1:0]  mem_addr,
  output logic [15:0]                   mem_wdata,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic                          cpu_hold
);

  localparam int unsigned AW = addr_width(DEPTH);
  localparam int unsigned LW = AW + 1;

  loader_state_t   state_q, state_n;
  logic [7:0]      hi_q;
  logic [LW-1:0]   len_q;
  logic [LW-1:0]   addr_q;

  logic            in_load_c;
  logic            start_acc_c;
  logic            byte_acc_c;
  logic            tmr_clear_c;
  logic            tmo_c;
  logic [15:0]     hdr_len_c;
  logic            len_bad_c;
  logic            last_word_c;

  assign in_load_c   = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                       (state_q == ST_DATA_HI) || (state_q == ST_DATA_LO);
  assign start_acc_c = start && !in_load_c;
  assign byte_acc_c  = rx_valid && in_load_c;
  assign tmr_clear_c = start_acc_c || byte_acc_c;

  assign hdr_len_c   = join_bytes(hi_q, rx_data);
  assign len_bad_c   = (hdr_len_c == 16'd0) || (hdr_len_c > 16'(DEPTH));
  assign last_word_c = ((addr_q + LW'(1)) == len_q);

  idle_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmr_clear_c),
    .enable (in_load_c),
    .tc_c   (tmo_c)
  );

  // Next state; an arriving byte takes priority over the timeout.
  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) state_n = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (rx_valid)   state_n = ST_LEN_LO;
        else if (tmo_c) state_n = ST_ERROR;
      end
      ST_LEN_LO: begin
        if (rx_valid)   state_n = len_bad_c ? ST_ERROR : ST_DATA_HI;
        else if (tmo_c) state_n = ST_ERROR;
      end
      ST_DATA_HI: begin
        if (rx_valid)   state_n = ST_DATA_LO;
        else if (tmo_c) state_n = ST_ERROR;
      end
      ST_DATA_LO: begin
        if (rx_valid)   state_n = last_word_c ? ST_DONE : ST_DATA_HI;
        else if (tmo_c) state_n = ST_ERROR;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs (flags decoded from the next state).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      hi_q      <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      cpu_hold  <= 1'b1;
    end else begin
      state_q <= state_n;
      mem_we  <= 1'b0;
      if (byte_acc_c) begin
        case (state_q)
          ST_LEN_HI, ST_DATA_HI: hi_q <= rx_data;
          ST_LEN_LO: begin
            len_q  <= LW'(hdr_len_c);
            addr_q <= '0;
          end
          ST_DATA_LO: begin
            mem_we    <= 1'b1;
            mem_wdata <= join_bytes(hi_q, rx_data);
            mem_addr  <= addr_q[AW-1:0];
            addr_q    <= addr_q + LW'(1);
          end
          default: ;
        endcase
      end
      busy     <= (state_n == ST_LEN_HI) || (state_n == ST_LEN_LO) ||
                  (state_n == ST_DATA_HI) || (state_n == ST_DATA_LO);
      done     <= (state_n == ST_DONE);
      error    <= (state_n == ST_ERROR);
      cpu_hold <= (state_n != ST_DONE);
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: normal, bad-length, full-depth, timeout and reset loads.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        mem_we;
  logic [10:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_hold;

  int n_cmp = 0;
  int n_bad = 0;

  logic [10:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];

  program_loader #(
    .DEPTH          (2048),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .cpu_hold  (cpu_hold)
  );

  always #5 clk = ~clk;

  // Log every write pulse as the memory would see it.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_we"},    32'(mem_we),    32'd0);
    check_eq({tag, "_addr"},  32'(mem_addr),  32'd0);
    check_eq({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    check_eq({tag, "_busy"},  32'(busy),      32'd0);
    check_eq({tag, "_done"},  32'(done),      32'd0);
    check_eq({tag, "_error"}, 32'(error),     32'd0);
    check_eq({tag, "_hold"},  32'(cpu_hold),  32'd1);
  endtask

  initial begin
    logic [10:0] exp_addr[3];
    logic [15:0] exp_data[3];
    int          n_err;
    logic [15:0] w;

    exp_addr = '{11'd0, 11'd1, 11'd2};
    exp_data = '{16'h1234, 16'hABCD, 16'h0001};

    rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) tick();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    tick();
    check_reset_outputs("idle");

    // A byte in IDLE must not be consumed.
    send_byte(8'h55);
    tick();
    check_eq("idle_rx_busy", 32'(busy), 32'd0);
    check_eq("idle_rx_nowr", 32'(wr_addr_q.size()), 32'd0);

    // Normal load, with a start pulse mid-load that must be ignored.
    pulse_start();
    check_eq("start_busy", 32'(busy), 32'd1);
    check_eq("start_hold", 32'(cpu_hold), 32'd1);
    send_byte(8'h00); send_byte(8'h03);
    pulse_start();
    check_eq("start_in_busy", 32'(busy), 32'd1);
    send_byte(8'h12); send_byte(8'h34);
    check_eq("w0_we",    32'(mem_we),    32'd1);
    check_eq("w0_addr",  32'(mem_addr),  32'd0);
    check_eq("w0_data",  32'(mem_wdata), 32'h1234);
    send_byte(8'hAB); send_byte(8'hCD);
    send_byte(8'h00); send_byte(8'h01);
    check_eq("last_we",   32'(mem_we),    32'd1);
    check_eq("last_addr", 32'(mem_addr),  32'd2);
    check_eq("last_data", 32'(mem_wdata), 32'h0001);
    check_eq("last_done", 32'(done),      32'd1);
    check_eq("last_busy", 32'(busy),      32'd0);
    check_eq("last_hold", 32'(cpu_hold),  32'd0);
    tick();
    check_eq("we_one_cycle", 32'(mem_we), 32'd0);
    check_eq("done_sticky",  32'(done),   32'd1);
    check_eq("norm_nwr", 32'(wr_addr_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < wr_addr_q.size()) begin
        check_eq($sformatf("norm_addr%0d", i), 32'(wr_addr_q[i]), 32'(exp_addr[i]));
        check_eq($sformatf("norm_data%0d", i), 32'(wr_data_q[i]), 32'(exp_data[i]));
      end
    end

    // Start from DONE, then zero length.
    clear_log();
    pulse_start();
    check_eq("redo_done", 32'(done), 32'd0);
    check_eq("redo_hold", 32'(cpu_hold), 32'd1);
    check_eq("redo_busy", 32'(busy), 32'd1);
    send_byte(8'h00); send_byte(8'h00);
    check_eq("len0_error", 32'(error), 32'd1);
    check_eq("len0_busy",  32'(busy), 32'd0);
    check_eq("len0_hold",  32'(cpu_hold), 32'd1);
    repeat (2) tick();
    check_eq("len0_nowr", 32'(wr_addr_q.size()), 32'd0);

    // Length DEPTH+1.
    pulse_start();
    check_eq("restart_err_clr", 32'(error), 32'd0);
    send_byte(8'h08); send_byte(8'h01);
    check_eq("len2049_error", 32'(error), 32'd1);
    check_eq("len2049_hold",  32'(cpu_hold), 32'd1);
    repeat (2) tick();
    check_eq("len2049_nowr", 32'(wr_addr_q.size()), 32'd0);

    // start together with rx_valid from ERROR: the byte is dropped.
    start = 1'b1; rx_valid = 1'b1; rx_data = 8'hFF;
    tick();
    start = 1'b0; rx_valid = 1'b0;
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h56); send_byte(8'h78);
    check_eq("drop_done", 32'(done), 32'd1);
    tick();
    check_eq("drop_nwr", 32'(wr_addr_q.size()), 32'd1);
    if (wr_data_q.size() > 0) check_eq("drop_data", 32'(wr_data_q[0]), 32'h5678);

    // Byte arriving on the terminal-count cycle wins over the timeout.
    clear_log();
    pulse_start();
    repeat (15) tick();
    send_byte(8'h00);
    check_eq("tc_byte_err",  32'(error), 32'd0);
    check_eq("tc_byte_busy", 32'(busy), 32'd1);
    send_byte(8'h01); send_byte(8'h9A); send_byte(8'hBC);
    check_eq("tc_byte_done", 32'(done), 32'd1);
    tick();
    if (wr_data_q.size() > 0) check_eq("tc_byte_data", 32'(wr_data_q[0]), 32'h9ABC);
    else check_eq("tc_byte_nwr", 32'(wr_data_q.size()), 32'd1);

    // Full depth: 2048 words, no address wrap.
    clear_log();
    pulse_start();
    send_byte(8'h08); send_byte(8'h00);
    for (int i = 0; i < 2048; i++) begin
      w = 16'(i) ^ 16'h5A00;
      send_byte(w[15:8]);
      send_byte(w[7:0]);
    end
    check_eq("full_done", 32'(done), 32'd1);
    check_eq("full_last_addr", 32'(mem_addr), 32'd2047);
    tick();
    check_eq("full_nwr", 32'(wr_addr_q.size()), 32'd2048);
    n_err = 0;
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      w = 16'(i) ^ 16'h5A00;
      if ((wr_addr_q[i] !== 11'(i)) || (wr_data_q[i] !== w)) n_err++;
    end
    check_eq("full_order", 32'(n_err), 32'd0);

    // Timeout: one word of two, then silence.
    clear_log();
    pulse_start();
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34);
    repeat (15) tick();
    check_eq("tmo_pre_err",  32'(error), 32'd0);
    check_eq("tmo_pre_busy", 32'(busy), 32'd1);
    tick();
    check_eq("tmo_err",  32'(error), 32'd1);
    check_eq("tmo_busy", 32'(busy), 32'd0);
    check_eq("tmo_hold", 32'(cpu_hold), 32'd1);
    check_eq("tmo_nwr", 32'(wr_addr_q.size()), 32'd1);
    if (wr_addr_q.size() > 0) begin
      check_eq("tmo_addr", 32'(wr_addr_q[0]), 32'd0);
      check_eq("tmo_data", 32'(wr_data_q[0]), 32'h1234);
    end

    // Reset mid-load, then a clean load.
    pulse_start();
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    clear_log();
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hBE); send_byte(8'hEF);
    check_eq("post_rst_done", 32'(done), 32'd1);
    check_eq("post_rst_hold", 32'(cpu_hold), 32'd0);
    tick();
    check_eq("post_rst_nwr", 32'(wr_addr_q.size()), 32'd1);
    if (wr_addr_q.size() > 0) begin
      check_eq("post_rst_addr", 32'(wr_addr_q[0]), 32'd0);
      check_eq("post_rst_data", 32'(wr_data_q[0]), 32'hBEEF);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
